// File: rtl/vs_uart_pkg.sv
// rtl/vs_uart_pkg.sv - shared types and helpers for the VS UART family
// UART_RX_BREAK_DET_EN adds the BRK receiver state.
package vs_uart_pkg;

  typedef enum logic [1:0] {
    PAR_NONE = 2'd0,
    PAR_ODD  = 2'd1,
    PAR_EVEN = 2'd2
  } parity_e;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_START = 3'd1,
    ST_DATA  = 3'd2,
    ST_PAR   = 3'd3,
    ST_STOP  = 3'd4,
    ST_PUSH  = 3'd5
`ifdef UART_RX_BREAK_DET_EN
    , ST_BRK = 3'd6
`endif
  } rx_state_e;

  // Rounded clocks-per-tick, never below one.
  function automatic int calc_div(input int clk_hz, input int baud, input int ovs);
    int den;
    int q;
    den = baud * ovs;
    q   = (clk_hz + den / 2) / den;
    return (q < 1) ? 1 : q;
  endfunction

  function automatic int fifo_width(input int data_bits);
    return data_bits + 2;
  endfunction

endpackage

// File: rtl/vs_sync_fifo.sv
// rtl/vs_sync_fifo.sv - first-word-fall-through FIFO with occupancy and drop strobe
module vs_sync_fifo #(
  parameter int WIDTH = 10,
  parameter int DEPTH = 16
) (
  input  logic                     CLK,
  input  logic                     SYS_NRST,
  input  logic                     wr_en,
  input  logic [WIDTH-1:0]         wr_data,
  input  logic                     rd_en,
  output logic [WIDTH-1:0]         rd_data,
  output logic                     empty,
  output logic                     full,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     wr_drop
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [AW:0]      wr_ptr_q, wr_ptr_d;
  logic [AW:0]      rd_ptr_q, rd_ptr_d;
  logic             do_wr;
  logic             do_rd;

  assign empty   = (wr_ptr_q == rd_ptr_q);
  assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign level   = wr_ptr_q - rd_ptr_q;
  assign rd_data = mem_q[rd_ptr_q[AW-1:0]];

  // A write while full is only accepted when the head leaves in the same cycle.
  assign do_rd   = rd_en && !empty;
  assign do_wr   = wr_en && (!full || rd_en);
  assign wr_drop = wr_en && full && !rd_en;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (do_wr) begin
      mem_d[wr_ptr_q[AW-1:0]] = wr_data;
      wr_ptr_d                = wr_ptr_q + 1'b1;
    end
    if (do_rd) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
  end

  always_ff @(posedge CLK or negedge SYS_NRST) begin
    if (!SYS_NRST) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      mem_q    <= mem_d;
    end
  end

endmodule

// File: rtl/vs_uart_rx_fifo.sv
// rtl/vs_uart_rx_fifo.sv - oversampling UART receiver feeding a FWFT frame FIFO
// UART_RX_BREAK_DET_EN adds break detection (BREAK port, BRK state).
module vs_uart_rx_fifo
  import vs_uart_pkg::*;
#(
  parameter int CLK_HZ     = 50000000,
  parameter int BAUD       = 115200,
  parameter int OVS        = 16,
  parameter int DATA_BITS  = 8,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                        CLK,
  input  logic                        SYS_NRST,
  input  logic                        RXD,
  input  logic                        RD_EN,
  output logic [DATA_BITS-1:0]        RD_DATA,
  output logic                        RD_FRM_ERR,
  output logic                        RD_PAR_ERR,
  output logic                        EMPTY,
  output logic                        FULL,
  output logic [$clog2(FIFO_DEPTH):0] LEVEL,
  output logic                        OVR_ERR,
`ifdef UART_RX_BREAK_DET_EN
  output logic                        BREAK,
`endif
  input  logic                        OVR_CLR
);

  localparam int DIV   = calc_div(CLK_HZ, BAUD, OVS);
  localparam int DIV_W = $clog2(DIV + 1);
  localparam int TW    = $clog2(OVS);
  localparam int BW    = $clog2(DATA_BITS);
  localparam int FW    = fifo_width(DATA_BITS);
  localparam logic [TW-1:0] S_LO  = TW'(OVS / 2 - 1);
  localparam logic [TW-1:0] S_MID = TW'(OVS / 2);
  localparam logic [TW-1:0] S_HI  = TW'(OVS / 2 + 1);

  rx_state_e            state_q, state_d;
  logic                 sync1_q, sync1_d, sync2_q, sync2_d, prev_q, prev_d;
  logic [DIV_W-1:0]     div_cnt_q, div_cnt_d;
  logic [TW-1:0]        tcnt_q, tcnt_d;
  logic                 s0_q, s0_d, s1_q, s1_d;
  logic [BW-1:0]        bit_cnt_q, bit_cnt_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 par_err_q, par_err_d;
  logic                 frm_err_q, frm_err_d;
  logic                 ovr_q, ovr_d;
`ifdef UART_RX_BREAK_DET_EN
  logic                 all_zero_q, all_zero_d;
  logic                 break_q, break_d;
`endif
  logic                 tick, centre, maj, push, wr_drop;
  logic [FW-1:0]        fifo_rd_data;

  assign tick   = (div_cnt_q == DIV_W'(DIV - 1));
  assign centre = tick && (tcnt_q == S_HI);
  assign maj    = (s0_q & s1_q) | (s0_q & sync2_q) | (s1_q & sync2_q);

  always_comb begin
    sync1_d   = RXD;
    sync2_d   = sync1_q;
    prev_d    = sync2_q;
    state_d   = state_q;
    div_cnt_d = div_cnt_q;
    tcnt_d    = tcnt_q;
    s0_d      = s0_q;
    s1_d      = s1_q;
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    par_err_d = par_err_q;
    frm_err_d = frm_err_q;
    ovr_d     = ovr_q;
    push      = 1'b0;
`ifdef UART_RX_BREAK_DET_EN
    all_zero_d = all_zero_q;
    break_d    = 1'b0;
    if (centre && maj) all_zero_d = 1'b0;
`endif

    // Bit timing is anchored to the start edge: counters sit at zero while idle.
    if (state_q == ST_IDLE) begin
      div_cnt_d = '0;
      tcnt_d    = '0;
    end else if (tick) begin
      div_cnt_d = '0;
      tcnt_d    = (tcnt_q == TW'(OVS - 1)) ? '0 : tcnt_q + 1'b1;
      if (tcnt_q == S_LO)  s0_d = sync2_q;
      if (tcnt_q == S_MID) s1_d = sync2_q;
    end else begin
      div_cnt_d = div_cnt_q + 1'b1;
    end

    case (state_q)
      ST_IDLE: begin
        if (prev_q && !sync2_q) begin
          state_d   = ST_START;
          bit_cnt_d = '0;
          par_err_d = 1'b0;
          frm_err_d = 1'b0;
`ifdef UART_RX_BREAK_DET_EN
          all_zero_d = 1'b1;
`endif
        end
      end
      ST_START: if (centre) state_d = maj ? ST_IDLE : ST_DATA;
      ST_DATA: begin
        if (centre) begin
          shift_d = {maj, shift_q[DATA_BITS-1:1]};
          if (bit_cnt_q == BW'(DATA_BITS - 1)) begin
            bit_cnt_d = '0;
            state_d   = (PARITY != int'(PAR_NONE)) ? ST_PAR : ST_STOP;
          end else begin
            bit_cnt_d = bit_cnt_q + 1'b1;
          end
        end
      end
      ST_PAR: begin
        if (centre) begin
          par_err_d = ((^shift_q) ^ maj) != (PARITY == int'(PAR_ODD));
          state_d   = ST_STOP;
        end
      end
      // Leave at the last stop centre so a back-to-back start edge is not missed.
      ST_STOP: begin
        if (centre) begin
          if (!maj) frm_err_d = 1'b1;
          if (bit_cnt_q == BW'(STOP_BITS - 1)) begin
`ifdef UART_RX_BREAK_DET_EN
            if (all_zero_q && !maj) begin
              break_d = 1'b1;
              state_d = ST_BRK;
            end else begin
              state_d = ST_PUSH;
            end
`else
            state_d = ST_PUSH;
`endif
          end else begin
            bit_cnt_d = bit_cnt_q + 1'b1;
          end
        end
      end
      ST_PUSH: begin
        push    = 1'b1;
        state_d = ST_IDLE;
      end
`ifdef UART_RX_BREAK_DET_EN
      ST_BRK: if (sync2_q) state_d = ST_IDLE;
`endif
      default: state_d = ST_IDLE;
    endcase

    if (OVR_CLR) ovr_d = 1'b0;
    if (wr_drop) ovr_d = 1'b1;
  end

  always_ff @(posedge CLK or negedge SYS_NRST) begin
    if (!SYS_NRST) begin
      state_q    <= ST_IDLE;
      sync1_q    <= 1'b1;
      sync2_q    <= 1'b1;
      prev_q     <= 1'b1;
      div_cnt_q  <= '0;
      tcnt_q     <= '0;
      s0_q       <= 1'b1;
      s1_q       <= 1'b1;
      bit_cnt_q  <= '0;
      shift_q    <= '0;
      par_err_q  <= 1'b0;
      frm_err_q  <= 1'b0;
      ovr_q      <= 1'b0;
`ifdef UART_RX_BREAK_DET_EN
      all_zero_q <= 1'b0;
      break_q    <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      sync1_q    <= sync1_d;
      sync2_q    <= sync2_d;
      prev_q     <= prev_d;
      div_cnt_q  <= div_cnt_d;
      tcnt_q     <= tcnt_d;
      s0_q       <= s0_d;
      s1_q       <= s1_d;
      bit_cnt_q  <= bit_cnt_d;
      shift_q    <= shift_d;
      par_err_q  <= par_err_d;
      frm_err_q  <= frm_err_d;
      ovr_q      <= ovr_d;
`ifdef UART_RX_BREAK_DET_EN
      all_zero_q <= all_zero_d;
      break_q    <= break_d;
`endif
    end
  end

  vs_sync_fifo #(
    .WIDTH (FW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .CLK      (CLK),
    .SYS_NRST (SYS_NRST),
    .wr_en    (push),
    .wr_data  ({frm_err_q, par_err_q, shift_q}),
    .rd_en    (RD_EN),
    .rd_data  (fifo_rd_data),
    .empty    (EMPTY),
    .full     (FULL),
    .level    (LEVEL),
    .wr_drop  (wr_drop)
  );

  assign {RD_FRM_ERR, RD_PAR_ERR, RD_DATA} = fifo_rd_data;
  assign OVR_ERR = ovr_q;
`ifdef UART_RX_BREAK_DET_EN
  assign BREAK = break_q;
`endif

endmodule

// File: tb/tb_vs_uart_rx_fifo.sv
// tb/tb_vs_uart_rx_fifo.sv - directed bench: instance a is 8N1/depth 16, instance b is 8E2/depth 4
// Builds with or without UART_RX_BREAK_DET_EN.
`timescale 1ns/1ps
module tb_vs_uart_rx_fifo;

  logic CLK = 1'b0;
  always #5 CLK = ~CLK;

  logic       SYS_NRST;
  logic       rxd_a, rd_en_a, ovr_clr_a, frm_a, par_a, empty_a, full_a, ovr_a;
  logic       rxd_b, rd_en_b, ovr_clr_b, frm_b, par_b, empty_b, full_b, ovr_b;
  logic [7:0] data_a, data_b;
  logic [4:0] level_a;
  logic [2:0] level_b;
  logic [7:0] c3 = 8'hC3;
  logic [7:0] v;
  int         checks = 0;
  int         errors = 0;
`ifdef UART_RX_BREAK_DET_EN
  logic       brk_a, brk_b;
  int         brk_cnt = 0;
  always @(negedge CLK) if (brk_a === 1'b1) brk_cnt++;
`endif

  vs_uart_rx_fifo #(
    .CLK_HZ(1843200), .BAUD(115200), .OVS(16), .DATA_BITS(8),
    .PARITY(0), .STOP_BITS(1), .FIFO_DEPTH(16)
  ) dut_a (
    .CLK(CLK), .SYS_NRST(SYS_NRST), .RXD(rxd_a), .RD_EN(rd_en_a),
    .RD_DATA(data_a), .RD_FRM_ERR(frm_a), .RD_PAR_ERR(par_a),
    .EMPTY(empty_a), .FULL(full_a), .LEVEL(level_a), .OVR_ERR(ovr_a),
`ifdef UART_RX_BREAK_DET_EN
    .BREAK(brk_a),
`endif
    .OVR_CLR(ovr_clr_a)
  );

  vs_uart_rx_fifo #(
    .CLK_HZ(1843200), .BAUD(115200), .OVS(16), .DATA_BITS(8),
    .PARITY(2), .STOP_BITS(2), .FIFO_DEPTH(4)
  ) dut_b (
    .CLK(CLK), .SYS_NRST(SYS_NRST), .RXD(rxd_b), .RD_EN(rd_en_b),
    .RD_DATA(data_b), .RD_FRM_ERR(frm_b), .RD_PAR_ERR(par_b),
    .EMPTY(empty_b), .FULL(full_b), .LEVEL(level_b), .OVR_ERR(ovr_b),
`ifdef UART_RX_BREAK_DET_EN
    .BREAK(brk_b),
`endif
    .OVR_CLR(ovr_clr_b)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_rx(input bit which, input logic val);
    if (which) rxd_b = val;
    else       rxd_a = val;
  endtask

  // One bit is 16 clocks; a spike inverts the line for the clock at offset 9.
  task automatic drive_bit(input bit which, input logic val, input bit spike);
    for (int i = 0; i < 16; i++) begin
      set_rx(which, (spike && i == 9) ? ~val : val);
      @(negedge CLK);
    end
  endtask

  task automatic send_frame(input bit which, input logic [7:0] d, input logic pbit,
                            input logic last_stop, input int spike_bit);
    drive_bit(which, 1'b0, 1'b0);
    for (int i = 0; i < 8; i++) drive_bit(which, d[i], spike_bit == i);
    if (which) begin
      drive_bit(1'b1, pbit, 1'b0);
      drive_bit(1'b1, 1'b1, 1'b0);
    end
    drive_bit(which, last_stop, 1'b0);
    set_rx(which, 1'b1);
  endtask

  task automatic wait_ready(input bit which, input int budget, input string tag);
    for (int i = 0; i < budget; i++) begin
      if (!(which ? empty_b : empty_a)) break;
      @(negedge CLK);
    end
    chk(tag, which ? empty_b : empty_a, 1'b0);
  endtask

  task automatic pop(input bit which);
    if (which) rd_en_b = 1'b1;
    else       rd_en_a = 1'b1;
    @(negedge CLK);
    rd_en_a = 1'b0;
    rd_en_b = 1'b0;
  endtask

  initial begin
    SYS_NRST = 1'b0;
    rxd_a = 1'b1; rd_en_a = 1'b0; ovr_clr_a = 1'b0;
    rxd_b = 1'b1; rd_en_b = 1'b0; ovr_clr_b = 1'b0;
    repeat (3) @(negedge CLK);
    chk("rst_empty_a", empty_a, 1'b1);
    chk("rst_full_a", full_a, 1'b0);
    chk("rst_level_a", level_a, 5'd0);
    chk("rst_ovr_a", ovr_a, 1'b0);
    chk("rst_data_a", data_a, 8'h00);
    chk("rst_flags_a", {frm_a, par_a}, 2'b00);
    chk("rst_empty_b", empty_b, 1'b1);
    chk("rst_level_b", level_b, 3'd0);
    SYS_NRST = 1'b1;
    repeat (4) @(negedge CLK);

    send_frame(1'b0, 8'hA5, 1'b0, 1'b1, -1);
    wait_ready(1'b0, 20, "a5_avail");
    chk("a5_data", data_a, 8'hA5);
    chk("a5_flags", {frm_a, par_a}, 2'b00);
    chk("a5_level", level_a, 5'd1);
    pop(1'b0);
    chk("a5_popped_empty", empty_a, 1'b1);

    set_rx(1'b0, 1'b0);
    repeat (4) @(negedge CLK);
    set_rx(1'b0, 1'b1);
    repeat (40) @(negedge CLK);
    chk("glitch_empty", empty_a, 1'b1);

    send_frame(1'b0, 8'h0F, 1'b0, 1'b1, 2);
    wait_ready(1'b0, 20, "spike_avail");
    chk("spike_data", data_a, 8'h0F);
    chk("spike_frm", frm_a, 1'b0);
    pop(1'b0);

    set_rx(1'b0, 1'b0);
    repeat (192) @(negedge CLK);
    set_rx(1'b0, 1'b1);
    repeat (20) @(negedge CLK);
`ifdef UART_RX_BREAK_DET_EN
    chk("brk_pulses", brk_cnt, 1);
    chk("brk_level", level_a, 5'd0);
`else
    chk("brk_level", level_a, 5'd1);
    chk("brk_data", data_a, 8'h00);
    chk("brk_frm", frm_a, 1'b1);
    pop(1'b0);
`endif

    send_frame(1'b1, 8'h03, 1'b1, 1'b1, -1);
    wait_ready(1'b1, 20, "p03_avail");
    chk("p03_data", data_b, 8'h03);
    chk("p03_par_err", par_b, 1'b1);
    chk("p03_frm", frm_b, 1'b0);
    pop(1'b1);
    send_frame(1'b1, 8'h07, 1'b1, 1'b1, -1);
    wait_ready(1'b1, 20, "p07_avail");
    chk("p07_data", data_b, 8'h07);
    chk("p07_par_err", par_b, 1'b0);
    pop(1'b1);

    send_frame(1'b1, 8'h55, 1'b0, 1'b0, -1);
    wait_ready(1'b1, 20, "s55_avail");
    chk("s55_data", data_b, 8'h55);
    chk("s55_frm", frm_b, 1'b1);
    chk("s55_par", par_b, 1'b0);
    pop(1'b1);
    repeat (8) @(negedge CLK);
    send_frame(1'b1, 8'h12, 1'b0, 1'b1, -1);
    wait_ready(1'b1, 20, "s12_avail");
    chk("s12_data", data_b, 8'h12);
    chk("s12_frm", frm_b, 1'b0);
    pop(1'b1);

    for (int k = 1; k <= 5; k++) begin
      v = k[7:0];
      send_frame(1'b1, v, ^v, 1'b1, -1);
    end
    repeat (4) @(negedge CLK);
    chk("ovf_full", full_b, 1'b1);
    chk("ovf_level", level_b, 3'd4);
    chk("ovf_ovr", ovr_b, 1'b1);
    for (int k = 1; k <= 4; k++) begin
      v = k[7:0];
      chk("ovf_order", data_b, v);
      pop(1'b1);
    end
    chk("ovf_drained", empty_b, 1'b1);
    chk("ovf_sticky", ovr_b, 1'b1);
    ovr_clr_b = 1'b1;
    @(negedge CLK);
    ovr_clr_b = 1'b0;
    chk("ovf_cleared", ovr_b, 1'b0);

    send_frame(1'b0, 8'h81, 1'b0, 1'b1, -1);
    wait_ready(1'b0, 20, "pre_rst_avail");
    chk("pre_rst_level", level_a, 5'd1);
    drive_bit(1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) drive_bit(1'b0, c3[i], 1'b0);
    set_rx(1'b0, c3[3]);
    repeat (8) @(negedge CLK);
    SYS_NRST = 1'b0;
    repeat (2) @(negedge CLK);
    chk("mid_rst_empty", empty_a, 1'b1);
    chk("mid_rst_level", level_a, 5'd0);
    chk("mid_rst_data", data_a, 8'h00);
    chk("mid_rst_flags", {frm_a, par_a, ovr_a, full_a}, 4'b0000);
    set_rx(1'b0, 1'b1);
    SYS_NRST = 1'b1;
    repeat (200) @(negedge CLK);
    chk("post_rst_no_push", empty_a, 1'b1);
    send_frame(1'b0, 8'h3C, 1'b0, 1'b1, -1);
    wait_ready(1'b0, 20, "r3c_avail");
    chk("r3c_data", data_a, 8'h3C);
    chk("r3c_frm", frm_a, 1'b0);
    chk("r3c_level", level_a, 5'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/vs_uart_rx_fifo.md
Name: vs_uart_rx_fifo

Overview:
Parametrised UART receiver for the VS UART controller family. Configurable data width, parity mode, stop-bit count and oversampling ratio; 3-sample majority voting at bit centre. Each received frame goes into a first-word-fall-through FIFO together with its per-frame frame/parity error flags. Sits between the board RXD pin and the command FSM; replaces the fixed 8-bit receive path and its single-word handoff.

Parameters:
CLK_HZ, 50000000, system clock frequency in Hz
BAUD, 115200, line rate in baud
OVS, 16, oversampling ratio (even, >= 8)
DATA_BITS, 8, data bits per frame (5..9)
PARITY, 0, parity mode: 0 none, 1 odd, 2 even
STOP_BITS, 1, stop bits checked (1 or 2)
FIFO_DEPTH, 16, receive FIFO depth (power of 2, >= 2)

Ports:
CLK  in  1  system clock
SYS_NRST  in  1  asynchronous active-low reset
RXD  in  1  serial input, idle high, asynchronous to CLK
RD_EN  in  1  pop FIFO head; ignored when EMPTY
RD_DATA  out  DATA_BITS  FIFO head data, valid while !EMPTY
RD_FRM_ERR  out  1  frame-error flag of FIFO head
RD_PAR_ERR  out  1  parity-error flag of FIFO head (always 0 when PARITY=0)
EMPTY  out  1  FIFO empty
FULL  out  1  FIFO full
LEVEL  out  $clog2(FIFO_DEPTH)+1  FIFO occupancy
OVR_ERR  out  1  sticky overrun flag
OVR_CLR  in  1  clears OVR_ERR
BREAK  out  1  one-cycle break pulse (only with UART_RX_BREAK_DET_EN)

Behaviour:
- Reset: CLK and SYS_NRST; SYS_NRST asynchronous, active-low. All state clears. RD_DATA=0, RD_FRM_ERR=0, RD_PAR_ERR=0, EMPTY=1, FULL=0, LEVEL=0, OVR_ERR=0, BREAK=0. RXD synchroniser (2 flops) resets to 1. Reset mid-frame abandons the frame; nothing is pushed.
- Tick: DIV = round(CLK_HZ/(BAUD*OVS)), minimum 1. A one-cycle TICK fires every DIV clocks. The tick counter restarts on start-edge detection.
- Sampling: each bit spans OVS ticks. Samples are taken at ticks OVS/2-1, OVS/2 and OVS/2+1; the bit value is the 2-of-3 majority.
- FSM states: IDLE, START, DATA, PAR, STOP, PUSH.
  - IDLE -> START on synced RXD 1->0.
  - START: if the majority is 1 (false start), return to IDLE with no push. Otherwise go to DATA.
  - DATA: DATA_BITS bits, LSB first, into a shift register. Then go to PAR if PARITY!=0, else STOP.
  - PAR: par_err = (XOR(data) ^ parity_bit) != (PARITY==1).
  - STOP: STOP_BITS bits. frm_err=1 if any stop majority is 0.
  - PUSH: lasts 1 cycle, then IDLE. The FSM enters PUSH at the centre of the last stop bit, not its end, so a back-to-back start edge is caught.
- Push latency: word {frm_err, par_err, data} is written 1 CLK after the last stop-bit centre sample.
- FIFO: FWFT. Head outputs update the cycle after a pop or after a write into an empty FIFO. LEVEL is exact every cycle.
- Full: a push while FULL without RD_EN drops the word and sets OVR_ERR. A push and pop in the same cycle while FULL both succeed; OVR_ERR is not set.
- Empty: RD_EN while EMPTY has no effect. Simultaneous push and pop while EMPTY performs the push only.
- OVR_ERR: sticky until OVR_CLR. Set wins if overrun and OVR_CLR coincide.
- Pointer wrap-around: binary pointers with an extra MSB; full/empty derived from the MSB comparison.

Optional Feature:
UART_RX_BREAK_DET_EN
- Defined: a frame whose start, data, parity and stop samples are all 0 is a break.
  - BREAK pulses 1 cycle at the last stop centre and nothing is pushed.
  - The FSM then waits in state BRK until synced RXD=1 before returning to IDLE.
  - BREAK port is present.
- Undefined: a break is an ordinary frame pushed as data=0 with frm_err=1. No BREAK port, no BRK state.

Decomposition:
- Package vs_uart_pkg:
  - parity enum (PAR_NONE, PAR_ODD, PAR_EVEN)
  - FSM state enum
  - function calc_div(clk_hz, baud, ovs)
  - function for the FIFO word width (DATA_BITS+2)
- Sub-module vs_sync_fifo: parametrised width/depth FWFT FIFO with LEVEL, FULL, EMPTY. Reusable by the future TX path.

Test Plan:
Common configuration: CLK_HZ=1843200, BAUD=115200, OVS=16, so DIV=1 and one bit = 16 clocks.
1. 8N1: send 0xA5 -> EMPTY falls 18 CLK after the stop centre at the latest; RD_DATA=0xA5, RD_FRM_ERR=0, RD_PAR_ERR=0, LEVEL=1.
2. 8E1: send 0x03 with parity bit 1 (wrong) -> RD_DATA=0x03, RD_PAR_ERR=1. Then 0x07 with parity 1 (correct) -> RD_PAR_ERR=0.
3. 8N2: send 0x55 with second stop bit driven 0 -> RD_FRM_ERR=1; the next frame 0x12 is received cleanly.
4. 4-cycle low glitch on RXD in IDLE -> no push, EMPTY stays 1. A 1-tick spike in the middle of a data bit of 0x0F -> majority vote still yields 0x0F.
5. FIFO_DEPTH=4: send 5 frames 0x01..0x05 without RD_EN -> FULL=1, LEVEL=4, OVR_ERR=1, head=0x01. Pop 4 times -> 0x01..0x04 in order, then EMPTY=1. OVR_CLR -> OVR_ERR=0.
6. SYS_NRST asserted mid-data-bit of 0xC3 -> all outputs at reset values. After release, 0x3C is received correctly. With UART_RX_BREAK_DET_EN, 12 bit-times low -> BREAK pulses once, LEVEL stays 0.
